// File: rtl/button_sequence_capture_pkg.sv
// button_sequence_capture_pkg: level codes, slot lengths, index width, FSM states and level-to-length decode
package button_sequence_capture_pkg;
  localparam logic [2:0] LV1 = 3'b001;
  localparam logic [2:0] LV2 = 3'b010;
  localparam logic [2:0] LV3 = 3'b100;
  localparam int LEN_LV1 = 8;
  localparam int LEN_LV2 = 12;
  localparam int LEN_LV3 = 16;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  function automatic logic [4:0] level_len(input logic [2:0] lv);
    return lv == LV1 ? 5'(LEN_LV1) : lv == LV2 ? 5'(LEN_LV2) : lv == LV3 ? 5'(LEN_LV3) : 5'd0;
  endfunction
endpackage

// File: rtl/button_sequence_capture_if.sv
// button_sequence_capture_if: bus carrying enable/level/btn to the capture block and slots/slot_count/end_signal/led_echo back
interface button_sequence_capture_if #(parameter int NUM_BTN = 8, parameter int MAX_LEN = 16);
  logic                   enable;
  logic [2:0]             level;
  logic [NUM_BTN-1:0]     btn;
  logic [3*MAX_LEN-1:0]   slots;
  logic [4:0]             slot_count;
  logic                   end_signal;
  logic [NUM_BTN-1:0]     led_echo;
  modport master (output enable, level, btn, input slots, slot_count, end_signal, led_echo);
  modport slave (input enable, level, btn, output slots, slot_count, end_signal, led_echo);
endinterface

// File: rtl/button_sequence_capture_btn_debounce.sv
// btn_debounce: 2-flop sync of raw, db flips after DEBOUNCE_CYC equal samples, rise pulses on db 0->1 (clk, rst async low)
module btn_debounce #(parameter int DEBOUNCE_CYC = 20) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      db <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      rise <= 1'b0;
      if (s2 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt <= '0;
        db <= s2;
        rise <= s2;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/button_sequence_capture.sv
// button_sequence_capture: debounce buttons, record lowest pressed index per press into slots until level length reached (clk, rst async low, bus)
module button_sequence_capture
  import button_sequence_capture_pkg::*;
#(
  parameter int NUM_BTN = 8,
  parameter int MAX_LEN = 16,
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  button_sequence_capture_if.slave bus
);
  localparam int AW = $clog2(MAX_LEN);
  logic [NUM_BTN-1:0] db, press;
  state_t state;
  logic [4:0] target, count;
  logic hold, end_q;
  logic [IDX_W-1:0] slot_q [MAX_LEN];
  logic [IDX_W-1:0] idx;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst(rst), .raw(bus.btn[i]), .db(db[i]), .rise(press[i])
    );
  end
  always_comb begin
    idx = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) idx = press[k] ? IDX_W'(k) : idx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      target <= '0;
      count <= '0;
      hold <= 1'b0;
      end_q <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) slot_q[k] <= '0;
    end else begin
      end_q <= state == DONE;
      case (state)
        IDLE: if (bus.enable && level_len(bus.level) != 5'd0) begin
          state <= ARMED;
          target <= level_len(bus.level);
        end
        ARMED: if (!bus.enable) state <= IDLE;
          else if (db == '0) state <= CAPTURE;
        CAPTURE: if (!bus.enable) begin
          state <= IDLE;
          count <= '0;
          hold <= 1'b0;
          for (int k = 0; k < MAX_LEN; k++) slot_q[k] <= '0;
        end else if (hold) hold <= db != '0;
        else if (|press) begin
          slot_q[count[AW-1:0]] <= idx;
          count <= count + 5'd1;
          hold <= 1'b1;
          if (count + 5'd1 == target) state <= DONE;
        end
        default: ;
      endcase
    end
  end
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_out
    assign bus.slots[3*i +: 3] = slot_q[i];
  end
  assign bus.slot_count = count;
  assign bus.end_signal = end_q;
  assign bus.led_echo = (state == ARMED || state == CAPTURE) ? db : '0;
endmodule

// File: tb/tb_button_sequence_capture.sv
// tb_button_sequence_capture: table, directed and random checks of button_sequence_capture against a press-queue model
module tb_button_sequence_capture;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  int q[$];
  int target;
  typedef struct {logic [2:0] level; int presses; int exp_count; logic exp_end;} vec_t;
  vec_t tbl[7];
  button_sequence_capture_if #(.NUM_BTN(8), .MAX_LEN(16)) bus ();
  button_sequence_capture #(.NUM_BTN(8), .MAX_LEN(16), .DEBOUNCE_CYC(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic int len_of(input logic [2:0] lv);
    case (lv)
      3'b001: return 8;
      3'b010: return 12;
      3'b100: return 16;
      default: return 0;
    endcase
  endfunction
  function automatic int lowest(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return 0;
  endfunction
  function automatic logic [47:0] model_slots();
    logic [47:0] v = '0;
    foreach (q[i]) v[3*i +: 3] = 3'(q[i]);
    return v;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    bus.enable = 1'b0;
    bus.btn = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
  endtask
  task automatic start(input logic [2:0] lv);
    do_reset();
    target = len_of(lv);
    bus.level = lv;
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic press(input logic [7:0] mask, input int hold, input int rel);
    bus.btn = mask;
    repeat (hold) @(negedge clk);
    bus.btn = '0;
    repeat (rel) @(negedge clk);
    if (mask != 0 && q.size() < target) q.push_back(lowest(mask));
  endtask
  task automatic check_all(input string name);
    check({name, "_count"}, bus.slot_count, q.size());
    check({name, "_slots"}, bus.slots, model_slots());
    check({name, "_end"}, bus.end_signal, target != 0 && q.size() == target);
  endtask
  initial begin
    int b1[8] = '{3, 1, 8, 8, 2, 5, 7, 4};
    int e1[8] = '{2, 0, 7, 7, 1, 4, 6, 3};
    logic [47:0] v;
    int lat;
    logic hit;
    logic [2:0] lvs[3] = '{3'b001, 3'b010, 3'b100};
    tbl[0] = '{3'b001, 8, 8, 1'b1};
    tbl[1] = '{3'b010, 12, 12, 1'b1};
    tbl[2] = '{3'b100, 16, 16, 1'b1};
    tbl[3] = '{3'b011, 3, 0, 1'b0};
    tbl[4] = '{3'b000, 1, 0, 1'b0};
    tbl[5] = '{3'b001, 5, 5, 1'b0};
    tbl[6] = '{3'b010, 14, 12, 1'b1};
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.level = 3'b001;
    bus.btn = '0;
    #12;
    check("reset_slots", bus.slots, 0);
    check("reset_count", bus.slot_count, 0);
    check("reset_end", bus.end_signal, 0);
    check("reset_led", bus.led_echo, 0);
    // table: level decode, saturation and ignored extra presses
    for (int t = 0; t < 7; t++) begin
      start(tbl[t].level);
      for (int j = 0; j < tbl[t].presses; j++) press(8'(1 << ((j * 3 + 1) % 8)), 9, 9);
      check($sformatf("tbl%0d_count", t), bus.slot_count, tbl[t].exp_count);
      check($sformatf("tbl%0d_end", t), bus.end_signal, tbl[t].exp_end);
      check($sformatf("tbl%0d_slots", t), bus.slots, model_slots());
      check($sformatf("tbl%0d_led", t), bus.led_echo, 0);
    end
    // 1: level 001 full sequence, end_signal one cycle after last write
    start(3'b001);
    for (int j = 0; j < 7; j++) press(8'(1 << (b1[j] - 1)), 10, 10);
    bus.btn = 8'h08;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge clk);
      #1;
      if (bus.slot_count == 8) hit = 1'b1;
    end
    check("t1_8th_write", hit, 1);
    check("t1_end_at_write", bus.end_signal, 0);
    @(posedge clk);
    #1;
    check("t1_end_next", bus.end_signal, 1);
    @(negedge clk);
    bus.btn = '0;
    repeat (10) @(negedge clk);
    v = '0;
    for (int j = 0; j < 8; j++) v[3*j +: 3] = 3'(e1[j]);
    check("t1_slots", bus.slots, v);
    check("t1_count", bus.slot_count, 8);
    check("t1_led_done", bus.led_echo, 0);
    // 2: glitch rejected, then exact press latency
    start(3'b001);
    bus.btn = 8'h04;
    repeat (3) @(negedge clk);
    bus.btn = '0;
    repeat (10) @(negedge clk);
    check("t2_glitch", bus.slot_count, 0);
    bus.btn = 8'h20;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.slot_count == 1 && lat == 0) lat = k;
    end
    @(negedge clk);
    bus.btn = '0;
    check("t2_latency", lat, 7);
    check("t2_slot0", bus.slots[2:0], 5);
    // 3: simultaneous rise keeps lowest index
    start(3'b001);
    press(8'h42, 10, 10);
    press(8'h08, 10, 10);
    check("t3_slots", bus.slots, 48'h19);
    check("t3_count", bus.slot_count, 2);
    // 4: button held over from playback is not captured
    do_reset();
    target = 8;
    bus.level = 3'b001;
    bus.btn = 8'h01;
    repeat (10) @(negedge clk);
    bus.enable = 1'b1;
    repeat (15) @(negedge clk);
    check("t4_held_count", bus.slot_count, 0);
    check("t4_led_armed", bus.led_echo, 1);
    bus.btn = '0;
    repeat (10) @(negedge clk);
    press(8'h01, 10, 10);
    check("t4_count", bus.slot_count, 1);
    check("t4_slots", bus.slots, 0);
    // 6a: async reset mid-capture
    start(3'b010);
    for (int j = 0; j < 5; j++) press(8'(1 << (j + 2)), 9, 9);
    check("t6_count5", bus.slot_count, 5);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_count", bus.slot_count, 0);
    check("t6_rst_slots", bus.slots, 0);
    check("t6_rst_end", bus.end_signal, 0);
    @(negedge clk);
    rst = 1'b1;
    // 6b: enable dropped mid-capture clears on next edge
    start(3'b001);
    for (int j = 0; j < 3; j++) press(8'(1 << (j + 4)), 9, 9);
    check("t6_count3", bus.slot_count, 3);
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    check("t6_drop_count", bus.slot_count, 0);
    check("t6_drop_slots", bus.slots, 0);
    @(negedge clk);
    press(8'h02, 9, 9);
    check("t6_idle_press", bus.slot_count, 0);
    // random presses and glitches against the queue model
    for (int r = 0; r < 4; r++) begin
      start(lvs[$urandom_range(0, 2)]);
      for (int e = 0; e < 20; e++) begin
        if ($urandom_range(0, 9) < 7) press(8'($urandom_range(1, 255)), $urandom_range(8, 12), $urandom_range(8, 11));
        else begin
          bus.btn = 8'(1 << $urandom_range(0, 7));
          repeat ($urandom_range(1, 3)) @(negedge clk);
          bus.btn = '0;
          repeat (9) @(negedge clk);
        end
        check_all($sformatf("rnd%0d_%0d", r, e));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
